draw_arbiter: RTL and testbench

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arbiter_pkg.sv | 16 +
 rtl/draw_arbiter_if.sv | 37 +++
 rtl/draw_arbiter_rr_select.sv | 30 +++
 rtl/draw_arbiter.sv | 135 +++++++++++++
 tb/tb_draw_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/draw_arbiter_pkg.sv
// Shared definitions for the draw arbiter: FSM state encoding and default widths.
package draw_arbiter_pkg;

  localparam int unsigned DEF_NREQ = 3;  // 0 wall, 1 player, 2 score
  localparam int unsigned DEF_XW   = 8;
  localparam int unsigned DEF_YW   = 7;
  localparam int unsigned DEF_CW   = 3;
  localparam int unsigned DEF_SW   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/draw_arbiter_if.sv
// Request/plot bus between the object controllers and the draw arbiter.
interface draw_arbiter_if
  import draw_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned XW   = DEF_XW,
  parameter int unsigned YW   = DEF_YW,
  parameter int unsigned CW   = DEF_CW,
  parameter int unsigned SW   = DEF_SW
);

  logic [NREQ-1:0]    req;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ*YW-1:0] req_y;
  logic [NREQ*SW-1:0] req_w;
  logic [NREQ*SW-1:0] req_h;
  logic [NREQ*CW-1:0] req_colour;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [XW-1:0]      vga_x;
  logic [YW-1:0]      vga_y;
  logic [CW-1:0]      vga_colour;
  logic               plot;

  // Requester side (object controllers)
  modport master (
    output req, req_x, req_y, req_w, req_h, req_colour,
    input  grant, done, vga_x, vga_y, vga_colour, plot
  );

  // Arbiter side
  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_colour,
    output grant, done, vga_x, vga_y, vga_colour, plot
  );

endinterface

// File: rtl/draw_arbiter_rr_select.sv
// Round-robin picker: searches from last_owner+1 upward (mod NREQ), returns one-hot pick.
module rr_select
  import draw_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned OW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [OW-1:0]   last_owner_i,
  output logic [NREQ-1:0] pick_o
);

  logic [OW-1:0] idx;
  logic          found;

  // First requesting index after the previous owner wins
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = OW'((32'(last_owner_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Draw arbiter: grants the shared pixel plotter to one object controller at a
// time and scans its filled box row-major, one pixel per cycle.
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned XW   = DEF_XW,
  parameter int unsigned YW   = DEF_YW,
  parameter int unsigned CW   = DEF_CW,
  parameter int unsigned SW   = DEF_SW
) (
  input  logic           clk,
  input  logic           resetn,
  draw_arbiter_if.slave  bus
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q;
  logic [OW-1:0]   owner_q, last_owner_q, pick_idx;
  logic [NREQ-1:0] pick, grant_q, done_q;
  logic [XW-1:0]   x0_q, vga_x_q, sel_x;
  logic [YW-1:0]   y0_q, vga_y_q, sel_y;
  logic [SW-1:0]   w_q, h_q, sel_w, sel_h;
  logic [SW-1:0]   col_q, row_q, col_nxt, row_nxt;
  logic [CW-1:0]   colour_q, vga_colour_q, sel_colour;
  logic            plot_q, col_last, row_last;

  rr_select #(.NREQ(NREQ), .OW(OW)) u_rr (
    .req_i       (bus.req),
    .last_owner_i(last_owner_q),
    .pick_o      (pick)
  );

  // One-hot pick to index
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = OW'(i);
    end
  end

  // Box parameters of the picked requester
  always_comb begin
    sel_x      = bus.req_x[pick_idx*XW +: XW];
    sel_y      = bus.req_y[pick_idx*YW +: YW];
    sel_w      = bus.req_w[pick_idx*SW +: SW];
    sel_h      = bus.req_h[pick_idx*SW +: SW];
    sel_colour = bus.req_colour[pick_idx*CW +: CW];
  end

  // Scan-position bookkeeping for the pixel after the current one
  always_comb begin
    col_last = (col_q == w_q - SW'(1));
    row_last = (row_q == h_q - SW'(1));
    col_nxt  = col_last ? '0 : col_q + SW'(1);
    row_nxt  = col_last ? row_q + SW'(1) : row_q;
  end

  // Arbitration/scan FSM; outputs are registered alongside the state so the
  // pixel presented during each DRAW cycle is the one the counters point at.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      grant_q      <= '0;
      done_q       <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      colour_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            owner_q  <= pick_idx;
            grant_q  <= pick;
            x0_q     <= sel_x;
            y0_q     <= sel_y;
            w_q      <= sel_w;
            h_q      <= sel_h;
            colour_q <= sel_colour;
            col_q    <= '0;
            row_q    <= '0;
            if (sel_w == '0 || sel_h == '0) begin
              state_q <= DONE;
              done_q  <= pick;
            end else begin
              state_q      <= DRAW;
              plot_q       <= 1'b1;
              vga_x_q      <= sel_x;
              vga_y_q      <= sel_y;
              vga_colour_q <= sel_colour;
            end
          end
        end
        DRAW: begin
          if (col_last && row_last) begin
            state_q <= DONE;
            plot_q  <= 1'b0;
            done_q  <= grant_q;
          end else begin
            col_q   <= col_nxt;
            row_q   <= row_nxt;
            vga_x_q <= x0_q + XW'(col_nxt);
            vga_y_q <= y0_q + YW'(row_nxt);
          end
        end
        DONE: begin
          done_q       <= '0;
          grant_q      <= '0;
          last_owner_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.plot       = plot_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter with hand-computed expected values.
module tb_draw_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  draw_arbiter_if #(.NREQ(3), .XW(8), .YW(7), .CW(3), .SW(5)) bus ();

  draw_arbiter #(.NREQ(3), .XW(8), .YW(7), .CW(3), .SW(5)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_box(input int i, input logic [7:0] x, input logic [6:0] y,
                         input logic [4:0] w, input logic [4:0] h, input logic [2:0] c);
    bus.req_x[i*8 +: 8]      = x;
    bus.req_y[i*7 +: 7]      = y;
    bus.req_w[i*5 +: 5]      = w;
    bus.req_h[i*5 +: 5]      = h;
    bus.req_colour[i*3 +: 3] = c;
  endtask

  task automatic chk_px(input string tag, input logic [2:0] g, input logic [7:0] x,
                        input logic [6:0] y, input logic [2:0] c);
    chk({tag, "_plot"},   32'(bus.plot), 32'd1);
    chk({tag, "_grant"},  32'(bus.grant), 32'(g));
    chk({tag, "_done"},   32'(bus.done), 32'd0);
    chk({tag, "_x"},      32'(bus.vga_x), 32'(x));
    chk({tag, "_y"},      32'(bus.vga_y), 32'(y));
    chk({tag, "_colour"}, 32'(bus.vga_colour), 32'(c));
  endtask

  task automatic chk_done(input string tag, input logic [2:0] g);
    chk({tag, "_plot"},  32'(bus.plot), 32'd0);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
    chk({tag, "_done"},  32'(bus.done), 32'(g));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_plot"},  32'(bus.plot), 32'd0);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn         = 1'b0;
    bus.req        = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_w      = '0;
    bus.req_h      = '0;
    bus.req_colour = '0;
    #1;
    chk_idle("rst");
    chk("rst_vga_x", 32'(bus.vga_x), 32'd0);
    chk("rst_vga_y", 32'(bus.vga_y), 32'd0);
    chk("rst_colour", 32'(bus.vga_colour), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk_idle("idle_noreq");

    // 2x2 box for requester 0
    set_box(0, 8'd10, 7'd5, 5'd2, 5'd2, 3'b100);
    bus.req = 3'b001;
    tick(); chk_px("b22_p0", 3'b001, 8'd10, 7'd5, 3'b100);
    tick(); chk_px("b22_p1", 3'b001, 8'd11, 7'd5, 3'b100);
    tick(); chk_px("b22_p2", 3'b001, 8'd10, 7'd6, 3'b100);
    tick(); chk_px("b22_p3", 3'b001, 8'd11, 7'd6, 3'b100);
    tick(); chk_done("b22_done", 3'b001);
    bus.req = 3'b000;
    tick(); chk_idle("b22_idle");
    tick(); chk_idle("b22_idle2");

    // Round-robin from reset with all three requesting 1x1 boxes
    do_reset();
    for (int i = 0; i < 3; i++) set_box(i, 8'(i*10 + 1), 7'(i + 1), 5'd1, 5'd1, 3'(i + 1));
    bus.req = 3'b111;
    begin
      logic [2:0] order [4];
      int         owner [4];
      order = '{3'b001, 3'b010, 3'b100, 3'b001};
      owner = '{0, 1, 2, 0};
      for (int n = 0; n < 4; n++) begin
        tick();
        chk_px($sformatf("rr%0d_px", n), order[n], 8'(owner[n]*10 + 1),
               7'(owner[n] + 1), 3'(owner[n] + 1));
        if (n == 3) bus.req = 3'b000;
        tick(); chk_done($sformatf("rr%0d_done", n), order[n]);
        tick(); chk_idle($sformatf("rr%0d_idle", n));
      end
    end

    // Zero-width box from requester 1: straight to done, no plot
    set_box(1, 8'd50, 7'd50, 5'd0, 5'd4, 3'b010);
    bus.req = 3'b010;
    tick(); chk_done("zw_done", 3'b010);
    bus.req = 3'b000;
    tick(); chk_idle("zw_idle");

    // X wrap-around for requester 2
    set_box(2, 8'd254, 7'd3, 5'd4, 5'd1, 3'b011);
    bus.req = 3'b100;
    tick(); chk_px("wrap_p0", 3'b100, 8'd254, 7'd3, 3'b011);
    tick(); chk_px("wrap_p1", 3'b100, 8'd255, 7'd3, 3'b011);
    tick(); chk_px("wrap_p2", 3'b100, 8'd0,   7'd3, 3'b011);
    tick(); chk_px("wrap_p3", 3'b100, 8'd1,   7'd3, 3'b011);
    tick(); chk_done("wrap_done", 3'b100);
    bus.req = 3'b000;
    tick(); chk_idle("wrap_idle");

    // Owner drops req mid-box while inputs change; latched box must complete
    set_box(0, 8'd20, 7'd10, 5'd3, 5'd1, 3'b010);
    bus.req = 3'b001;
    tick(); chk_px("lat_p0", 3'b001, 8'd20, 7'd10, 3'b010);
    set_box(0, 8'd90, 7'd60, 5'd7, 5'd7, 3'b111);
    set_box(1, 8'd100, 7'd30, 5'd1, 5'd1, 3'b101);
    bus.req = 3'b010;
    tick(); chk_px("lat_p1", 3'b001, 8'd21, 7'd10, 3'b010);
    tick(); chk_px("lat_p2", 3'b001, 8'd22, 7'd10, 3'b010);
    tick(); chk_done("lat_done", 3'b001);
    tick(); chk_idle("lat_idle");
    tick(); chk_px("lat_next", 3'b010, 8'd100, 7'd30, 3'b101);
    bus.req = 3'b000;
    tick(); chk_done("lat_next_done", 3'b010);
    tick(); chk_idle("lat_next_idle");

    // Reset during third pixel of a 3x3 box, then full redraw
    do_reset();
    set_box(0, 8'd40, 7'd20, 5'd3, 5'd3, 3'b111);
    bus.req = 3'b001;
    tick(); chk_px("rd_p0", 3'b001, 8'd40, 7'd20, 3'b111);
    tick(); chk_px("rd_p1", 3'b001, 8'd41, 7'd20, 3'b111);
    tick(); chk_px("rd_p2", 3'b001, 8'd42, 7'd20, 3'b111);
    #2;
    resetn = 1'b0;
    #1;
    chk_idle("rd_async");
    chk("rd_async_x", 32'(bus.vga_x), 32'd0);
    chk("rd_async_colour", 32'(bus.vga_colour), 32'd0);
    tick(); chk_idle("rd_held");
    resetn = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        chk_px($sformatf("rd2_p%0d%0d", r, c), 3'b001, 8'(40 + c), 7'(20 + r), 3'b111);
      end
    end
    bus.req = 3'b000;
    tick(); chk_done("rd2_done", 3'b001);
    tick(); chk_idle("rd2_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
